// File: rtl/framebuffer_arbiter_if.sv
// Bundles the scan-side read port, host write port, swap control and RAM bus
// of the framebuffer arbiter. The slave modport is the arbiter's view.
interface framebuffer_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 18
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              swap_req;
  logic              frame_start;
  logic              swap_pending;
  logic              front_bank;

  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_start, mem_rdata,
    output rd_ack, rd_valid, rd_data, wr_ack, swap_pending, front_bank,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_start, mem_rdata,
    input  rd_ack, rd_valid, rd_data, wr_ack, swap_pending, front_bank,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Double-buffered framebuffer arbiter: scan reads from the front bank, host
// writes the back bank, banks swap on the first frame_start after a swap request.
module framebuffer_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 18,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  framebuffer_arbiter_if.slave  bus
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    RUN       = 1'b0,
    SWAP_WAIT = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic                front_bank_reg, front_bank_next;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic                rd_valid_reg;
  logic [DATA_W-1:0]   rd_hold_reg;
  logic                writes_ok;
  logic                rd_grant;
  logic                wr_grant;

  always_comb begin
    state_next      = state_reg;
    front_bank_next = front_bank_reg;
    starve_cnt_next = '0;
    rd_grant        = 1'b0;
    wr_grant        = 1'b0;
    writes_ok       = (state_reg == RUN);

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    if (reset) begin
      if (bus.wr_req && writes_ok && (!bus.rd_req || starve_cnt_reg == STARVE_MAX)) begin
        wr_grant = 1'b1;
      end else if (bus.rd_req) begin
        rd_grant = 1'b1;
      end
    end

    if (bus.wr_req && writes_ok && !wr_grant) begin
      if (rd_grant && starve_cnt_reg != STARVE_MAX) begin
        starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
      end else begin
        starve_cnt_next = starve_cnt_reg;
      end
    end

    case (state_reg)
      RUN: begin
        // A coincident frame_start is ignored here; the toggle waits a frame.
        if (bus.swap_req) begin
          state_next = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (bus.frame_start) begin
          state_next      = RUN;
          front_bank_next = ~front_bank_reg;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      front_bank_reg <= 1'b0;
      starve_cnt_reg <= '0;
      rd_valid_reg   <= 1'b0;
      rd_hold_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      front_bank_reg <= front_bank_next;
      starve_cnt_reg <= starve_cnt_next;
      rd_valid_reg   <= rd_grant;
      if (rd_valid_reg) begin
        rd_hold_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.rd_ack       = rd_grant;
  assign bus.wr_ack       = wr_grant;
  assign bus.mem_re       = rd_grant;
  assign bus.mem_we       = wr_grant;
  assign bus.mem_addr     = rd_grant ? {front_bank_reg, bus.rd_addr} :
                            wr_grant ? {~front_bank_reg, bus.wr_addr} : '0;
  assign bus.mem_wdata    = wr_grant ? bus.wr_data : '0;
  assign bus.swap_pending = (state_reg == SWAP_WAIT);
  assign bus.front_bank   = front_bank_reg;
  assign bus.rd_valid     = rd_valid_reg;
  // RAM data passes straight through in the valid cycle and is held afterwards.
  assign bus.rd_data      = rd_valid_reg ? bus.mem_rdata : rd_hold_reg;
endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 11, pixel address width within one bank (64 columns x 16 rows x 2 halves).
REQ-002 Parameter: DATA_W, default 18, pixel word width (3 x 6-bit sub-pixel brightness).
REQ-003 Parameter: STARVE_LIMIT, default 8, maximum consecutive read grants while a write waits.
REQ-004 Port: clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Ports: rd_req in 1, rd_addr in ADDR_W, rd_ack out 1, rd_valid out 1, rd_data out DATA_W  scan-side read port.
REQ-007 Ports: wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ack out 1  host-side write port.
REQ-008 Ports: swap_req in 1 (pulse), frame_start in 1 (pulse, from the row scanner at row 0 / first brightness plane), swap_pending out 1, front_bank out 1.
REQ-009 Ports: mem_addr out ADDR_W+1, mem_wdata out DATA_W, mem_we out 1, mem_re out 1, mem_rdata in DATA_W  single-port RAM, synchronous read, 1-cycle latency.

Function
REQ-010 At most one of mem_re/mem_we SHALL be high in any cycle; rd_ack equals mem_re and wr_ack equals mem_we (combinational grant from req inputs and registered state).
REQ-011 Handshake: requester holds req and addr/data stable until ack; address/data are consumed in the ack cycle; the block may ack in the same cycle req rises.
REQ-012 Read grant: mem_addr = {front_bank, rd_addr}; rd_valid SHALL pulse exactly one cycle after rd_ack with rd_data = mem_rdata registered-through for that cycle.
REQ-013 Write grant: mem_addr = {~front_bank, wr_addr}, mem_wdata = wr_data; writes never target the front bank.
REQ-014 Priority: read wins when both request, except when starve_cnt == STARVE_LIMIT, in which case the write is granted.
REQ-015 starve_cnt (width clog2(STARVE_LIMIT+1)): increments on each read grant while wr_req is high and writes are eligible; clears on any write grant or whenever wr_req is low; saturates at STARVE_LIMIT.
REQ-016 State machine, two states: RUN and SWAP_WAIT.
REQ-017 RUN: writes eligible; swap_req -> SWAP_WAIT, swap_pending = 1 next cycle.
REQ-018 SWAP_WAIT: wr_ack held 0 (writes stalled, starve_cnt held at 0); reads served normally; further swap_req ignored.
REQ-019 SWAP_WAIT and frame_start: front_bank toggles, swap_pending clears, state -> RUN; all three take effect on the same edge.
REQ-020 A read granted in the frame_start cycle uses the pre-toggle front_bank; the first read after the edge uses the new front_bank.
REQ-021 swap_req and frame_start in the same cycle while in RUN: enter SWAP_WAIT only; the toggle waits for the next frame_start (no same-cycle swap).
REQ-022 A write acked in the same cycle as swap_req completes to the pre-swap back bank.
REQ-023 frame_start in RUN has no effect.

Reset
REQ-024 While reset is low: state RUN, front_bank 0, swap_pending 0, starve_cnt 0, rd_valid 0, rd_data 0, rd_ack/wr_ack/mem_re/mem_we 0, mem_addr 0, mem_wdata 0.
REQ-025 Reset asserted mid-swap discards the pending swap; a read in flight produces no rd_valid after reset.
REQ-026 The first grant may occur in the first cycle after reset deasserts.

Verification
REQ-027 Read only: rd_req=1, rd_addr=0x005, front_bank=0 -> mem_re=1, mem_addr=0x005, rd_ack=1; next cycle rd_valid=1, rd_data=RAM[0x005].
REQ-028 Write only: wr_req=1, wr_addr=0x010, wr_data=0x3FFFF -> wr_ack=1, mem_we=1, mem_addr=0x810 (bank 1).
REQ-029 Starvation: rd_req and wr_req held high continuously -> 8 read acks, then 1 write ack, then reads resume; pattern repeats.
REQ-030 Swap: swap_req pulse, wr_req held -> swap_pending=1, no wr_ack; after frame_start -> front_bank=1, swap_pending=0, next write lands at mem_addr 0x0xx (bank 0).
REQ-031 Coincident swap_req+frame_start in RUN -> front_bank stays 0, swap_pending=1; next frame_start -> front_bank=1.
REQ-032 Reset low during SWAP_WAIT -> all outputs at reset values; after release, wr_req is acked immediately to bank 1.
